fc3_sched: RTL and testbench

- Sequencer for the final fully-connected layer (FC3) of the LeNet co-processor.
- On `start`, it pulses `fc3_go` to the argmax stage and walks the 10 output neurons. For each neuron it issues bias, feature and weight reads and accumulates a signed MAC.
- Each finished neuron is emitted as one `fc3_q`/`fc3_q_en` beat. The block then waits for the argmax `ready` and reports `done`.
- It sits between the FC2 feature buffer / weight ROMs and the argmax digit stage.

---
 rtl/fc3_sched_pkg.sv | 32 +++
 rtl/fc3_sched_if.sv | 39 +++
 rtl/fc3_sched_mac.sv | 57 +++++
 rtl/fc3_sched.sv | 135 +++++++++++++
 tb/tb_fc3_sched.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fc3_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fc3_sched_pkg
//  Purpose  : Shared constants, address widths and FSM encoding for the FC3
//             layer sequencer of the LeNet co-processor.
//  Revision : 1.0  initial release
// ============================================================================
package fc3_sched_pkg;

    localparam int WD    = 16;   // signed 1_13 data width
    localparam int FRAC  = 13;   // fractional bits of WD-format values
    localparam int N_IN  = 84;   // inputs per neuron
    localparam int N_OUT = 10;   // output neurons
    localparam int ACC_W = 40;   // accumulator width (2*WD plus guard bits)

    localparam int J_W = $clog2(N_OUT);         // bias / neuron index width
    localparam int K_W = $clog2(N_IN);          // feature index width
    localparam int W_W = $clog2(N_OUT * N_IN);  // weight index width

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GO       = 3'd1,
        S_BIAS     = 3'd2,
        S_MAC      = 3'd3,
        S_DRAIN    = 3'd4,
        S_EMIT     = 3'd5,
        S_WAIT_RDY = 3'd6,
        S_DONE     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fc3_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : fc3_sched_if
//  Purpose  : Control, memory-read and result bus of the FC3 sequencer.
//             slave = sequencer side, master = environment side.
//  Revision : 1.0  initial release
// ============================================================================
interface fc3_sched_if;
    import fc3_sched_pkg::*;

    logic           start;
    logic           busy;
    logic           done;
    logic           fc3_go;
    logic           mem_rd;
    logic [J_W-1:0] bias_addr;
    logic [K_W-1:0] feat_addr;
    logic [W_W-1:0] wt_addr;
    logic [WD-1:0]  bias_q;
    logic [WD-1:0]  feat_q;
    logic [WD-1:0]  wt_q;
    logic [WD-1:0]  fc3_q;
    logic           fc3_q_en;
    logic           argmax_ready;

    modport slave (
        input  start, bias_q, feat_q, wt_q, argmax_ready,
        output busy, done, fc3_go, mem_rd, bias_addr, feat_addr, wt_addr,
               fc3_q, fc3_q_en
    );

    modport master (
        output start, bias_q, feat_q, wt_q, argmax_ready,
        input  busy, done, fc3_go, mem_rd, bias_addr, feat_addr, wt_addr,
               fc3_q, fc3_q_en
    );

endinterface
`default_nettype wire

// File: rtl/fc3_sched_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fc3_mac
//  Purpose  : Signed MAC for one FC3 neuron: bias load (aligned to FRAC),
//             product accumulation and narrowing of acc >>> FRAC to WD bits.
//             Build option FC3_SAT_EN: clamp instead of two's-complement wrap.
//  Revision : 1.0  initial release
// ============================================================================
module fc3_mac
    import fc3_sched_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load,
    input  wire logic          acc_en,
    input  wire logic [WD-1:0] bias,
    input  wire logic [WD-1:0] feat,
    input  wire logic [WD-1:0] wt,
    output logic      [WD-1:0] result
);

    localparam int SH_W = ACC_W - FRAC;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [2*WD-1:0]   w_prod;
    logic        [SH_W-1:0]   w_shr;
    logic                     w_unused;

    assign w_prod   = $signed(feat) * $signed(wt);
    // Taking the upper slice is the arithmetic right shift by FRAC.
    assign w_shr    = r_acc[ACC_W-1:FRAC];
    assign w_unused = ^{r_acc[FRAC-1:0], w_shr[SH_W-1:WD]};

    // Accumulator: bias load takes priority, then product accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= $signed({{(ACC_W-WD){bias[WD-1]}}, bias}) <<< FRAC;
        end else if (acc_en) begin
            r_acc <= r_acc + $signed({{(ACC_W-2*WD){w_prod[2*WD-1]}}, w_prod});
        end
    end

    // Narrow the shifted accumulator to WD bits.
    always_comb begin
        result = w_shr[WD-1:0];
`ifdef FC3_SAT_EN
        // Out of range when the bits above the WD sign bit disagree with it.
        if (w_shr[SH_W-1:WD-1] != {(SH_W-WD+1){w_shr[SH_W-1]}}) begin
            result = {w_shr[SH_W-1], {(WD-1){~w_shr[SH_W-1]}}};
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/fc3_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fc3_sched
//  Purpose  : FC3 layer sequencer. Pulses fc3_go, walks the 10 output
//             neurons issuing bias/feature/weight reads, emits one fc3_q beat
//             per neuron, then waits for argmax_ready and pulses done.
//             Build option FC3_SAT_EN selects saturating output narrowing.
//  Revision : 1.0  initial release
// ============================================================================
module fc3_sched
    import fc3_sched_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    fc3_sched_if.slave  bus
);

    state_t          r_state;
    state_t          w_next;
    logic [J_W-1:0]  r_j;
    logic [K_W-1:0]  r_k;
    logic [W_W-1:0]  r_wbase;     // j*N_IN, kept incrementally
    logic            r_ld_d;      // bias data arrives this cycle
    logic            r_mac_d;     // feature/weight data arrives this cycle
    logic [WD-1:0]   w_mac_q;

    // Addresses are straight from the index registers, so they hold
    // their last value whenever no read is issued.
    assign bus.bias_addr = r_j;
    assign bus.feat_addr = r_k;
    assign bus.wt_addr   = r_wbase + W_W'(r_k);

    fc3_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .load   (r_ld_d),
        .acc_en (r_mac_d),
        .bias   (bus.bias_q),
        .feat   (bus.feat_q),
        .wt     (bus.wt_q),
        .result (w_mac_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_next       = r_state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.fc3_go   = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.fc3_q    = '0;
        bus.fc3_q_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_GO;
            end
            S_GO: begin
                bus.busy   = 1'b1;
                bus.fc3_go = 1'b1;
                w_next     = S_BIAS;
            end
            S_BIAS: begin
                bus.busy   = 1'b1;
                bus.mem_rd = 1'b1;
                w_next     = S_MAC;
            end
            S_MAC: begin
                bus.busy   = 1'b1;
                bus.mem_rd = 1'b1;
                if (r_k == K_W'(N_IN - 1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                bus.busy = 1'b1;
                w_next   = S_EMIT;
            end
            S_EMIT: begin
                bus.busy     = 1'b1;
                bus.fc3_q_en = 1'b1;
                bus.fc3_q    = w_mac_q;
                w_next       = (r_j == J_W'(N_OUT - 1)) ? S_WAIT_RDY : S_BIAS;
            end
            S_WAIT_RDY: begin
                bus.busy = 1'b1;
                if (bus.argmax_ready) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Neuron/input indices and the one-cycle data-valid flags for the MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j     <= '0;
            r_k     <= '0;
            r_wbase <= '0;
            r_ld_d  <= 1'b0;
            r_mac_d <= 1'b0;
        end else begin
            r_ld_d  <= (r_state == S_BIAS);
            r_mac_d <= (r_state == S_MAC);
            case (r_state)
                S_GO: begin
                    r_j     <= '0;
                    r_wbase <= '0;
                end
                S_BIAS: r_k <= '0;
                S_MAC: begin
                    if (r_k != K_W'(N_IN - 1)) r_k <= r_k + K_W'(1);
                end
                S_EMIT: begin
                    if (r_j != J_W'(N_OUT - 1)) begin
                        r_j     <= r_j + J_W'(1);
                        r_wbase <= r_wbase + W_W'(N_IN);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc3_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc3_sched
//  Purpose  : Self-checking bench for fc3_sched: table of memory contents and
//             expected neuron outputs, plus restart-while-busy and mid-run
//             reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fc3_sched;
    import fc3_sched_pkg::*;

`ifdef FC3_SAT_EN
    localparam logic [WD-1:0] OVF_Q = 16'h7FFF;
`else
    localparam logic [WD-1:0] OVF_Q = 16'h7FAB;  // low 16 bits of 85*0x7FFF
`endif

    typedef struct {
        int                         mode;
        logic [N_OUT-1:0][WD-1:0]   exp_q;
        int                         digit;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk  = 0;
    vec_t vec [4];

    logic [WD-1:0] bias_mem [N_OUT];
    logic [WD-1:0] feat_mem [N_IN];
    logic [WD-1:0] wt_mem   [N_OUT*N_IN];

    fc3_sched_if bus ();

    fc3_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            bus.bias_q <= '0;
            bus.feat_q <= '0;
            bus.wt_q   <= '0;
        end else if (bus.mem_rd) begin
            bus.bias_q <= bias_mem[bus.bias_addr];
            bus.feat_q <= feat_mem[bus.feat_addr];
            bus.wt_q   <= wt_mem[bus.wt_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_mem(input int mode);
        for (int j = 0; j < N_OUT; j++) begin
            case (mode)
                0:       bias_mem[j] = WD'(j * 256);
                2:       bias_mem[j] = 16'h7FFF;
                3:       bias_mem[j] = 16'h8000;
                default: bias_mem[j] = 16'h0000;
            endcase
        end
        for (int k = 0; k < N_IN; k++) feat_mem[k] = 16'h2000;
        for (int i = 0; i < N_OUT*N_IN; i++) begin
            case (mode)
                1:       wt_mem[i] = (i / N_IN == 3) ? 16'h0100 : 16'h0000;
                2:       wt_mem[i] = 16'h7FFF;
                default: wt_mem[i] = 16'h0000;
            endcase
        end
    endtask

    // One run from a start pulse at cycle 0. restart_cyc re-pulses start,
    // rst_cyc (>0) pulses rst mid-run.
    task automatic run_case(input int vi, input int restart_cyc, input int rst_cyc);
        int beats = 0, done_cnt = 0, done_cyc = -1, go_cnt = 0, go_cyc = -1, digit = 0;
        logic [WD-1:0] got [N_OUT];
        logic signed [WD-1:0] best;
        load_mem(vec[vi].mode);
        for (int c = 0; c <= 900; c++) begin
            bus.start        = (c == 0) || (c == restart_cyc);
            bus.argmax_ready = (rst_cyc < 0) && (c == 872);
            rst              = (c == rst_cyc);
            if (bus.fc3_go) begin go_cnt++; go_cyc = c; end
            if (bus.done)   begin done_cnt++; done_cyc = c; end
            if (bus.fc3_q_en) begin
                if (beats < N_OUT) begin
                    check("q_en_cycle", c, 88 + 87 * beats);
                    check("fc3_q", bus.fc3_q, vec[vi].exp_q[beats]);
                    got[beats] = bus.fc3_q;
                end
                beats++;
            end
            if (rst_cyc < 0 && restart_cyc < 0) begin
                if (c == 1)   check("busy_c1", bus.busy, 1);
                if (c == 2)   check("bias_rd_c2", {bus.mem_rd, 4'(bus.bias_addr)}, {1'b1, 4'd0});
                if (c == 87)  check("drain_no_rd", bus.mem_rd, 0);
                if (c == 89)  check("bias_rd_c89", {bus.mem_rd, 4'(bus.bias_addr)}, {1'b1, 4'd1});
                if (c == 90)  check("wt_addr_c90", {bus.wt_addr, 7'(bus.feat_addr)}, {10'd84, 7'd0});
                if (c == 176) check("q_zero_off_emit", bus.fc3_q, 0);
                if (c == 872) check("busy_wait", bus.busy, 1);
                if (c == 873) check("busy_done", bus.busy, 0);
            end
            if (rst_cyc > 0 && c == rst_cyc + 1)
                check("after_rst", {bus.busy, bus.fc3_q_en, bus.mem_rd}, 0);
            @(negedge clk);
        end
        bus.start = 1'b0; bus.argmax_ready = 1'b0; rst = 1'b0;
        if (rst_cyc > 0) begin
            check("rst_beats", beats, 4);
            check("rst_no_done", done_cnt, 0);
        end else begin
            check("beats", beats, N_OUT);
            check("done_cnt", done_cnt, 1);
            check("done_cyc", done_cyc, 873);
            check("go_once_c1", {go_cnt[7:0], go_cyc[7:0]}, {8'd1, 8'd1});
            if (beats == N_OUT) begin
                best = $signed(got[0]);
                for (int j = 1; j < N_OUT; j++)
                    if ($signed(got[j]) > best) begin best = $signed(got[j]); digit = j; end
            end else digit = -1;
            check("digit", digit, vec[vi].digit);
        end
    endtask

    initial begin
        vec[0].mode = 0; vec[0].digit = 9;
        vec[1].mode = 1; vec[1].digit = 3;
        vec[2].mode = 2; vec[2].digit = 0;
        vec[3].mode = 3; vec[3].digit = 0;
        for (int j = 0; j < N_OUT; j++) begin
            vec[0].exp_q[j] = WD'(j * 256);
            vec[1].exp_q[j] = (j == 3) ? 16'h5400 : 16'h0000;
            vec[2].exp_q[j] = OVF_Q;
            vec[3].exp_q[j] = 16'h8000;
        end

        rst = 1'b1; bus.start = 1'b0; bus.argmax_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.busy, bus.done, bus.fc3_go, bus.mem_rd, bus.fc3_q_en}, 0);
        check("reset_addr", {bus.bias_addr, bus.feat_addr, bus.wt_addr}, 0);
        check("reset_q", bus.fc3_q, 0);
        // start together with rst: rst wins.
        bus.start = 1'b1;
        @(negedge clk);
        check("start_with_rst", {bus.busy, bus.fc3_go}, 0);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {bus.busy, bus.fc3_go}, 0);

        for (int v = 0; v < 4; v++) run_case(v, -1, -1);
        run_case(1, 300, -1);
        run_case(0, -1, 400);
        run_case(0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
